// File: rtl/fifo_pkg.sv
// Gray/binary pointer conversions and the depth validity rule for the dual-clock FIFO.
// Helpers work on 32-bit values; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

    localparam int MIN_DEPTH = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer; latency STAGES destination clocks.
// No flow control: samples d on every edge, all stages cleared by async rst.
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/async_fifo_flags.sv
// Dual-clock FIFO with Gray pointers, pessimistic fill counts and almost/over/underflow flags.
// Read data 1 clk_r after an accepted rd_en; writes while full are dropped, reads while empty ignored.
module async_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = FIFO_DEPTH - 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic                  clk_w,
    input  logic                  rst,
    input  logic                  clk_r,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

    if (!depth_ok(FIFO_DEPTH) || SYNC_STAGES < 2) begin : g_bad_cfg
        $error("async_fifo_flags: FIFO_DEPTH must be a power of 2 >= 4 and SYNC_STAGES >= 2");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wptr, wgray, wbin_next, wgray_next, rgray_sync, wr_count_next;
    logic [PW-1:0] rptr, rgray, rbin_next, rgray_next, wgray_sync, rd_count_next;
    logic          wr_fire, full_next, rd_fire, empty_next;

    // Write domain: full compares the next Gray pointer against the read pointer one lap behind.
    assign wr_fire       = wr_en && !full;
    assign wbin_next     = wptr + PW'(wr_fire);
    assign wgray_next    = PW'(bin2gray(32'(wbin_next)));
    assign full_next     = (wgray_next == {~rgray_sync[PW-1:PW-2], rgray_sync[PW-3:0]});
    assign wr_count_next = wbin_next - PW'(gray2bin(32'(rgray_sync)));

    always_ff @(posedge clk_w or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            wgray       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            overflow    <= 1'b0;
        end else begin
            wptr        <= wbin_next;
            wgray       <= wgray_next;
            full        <= full_next;
            almost_full <= (wr_count_next >= AF_CNT);
            wr_count    <= wr_count_next;
            overflow    <= wr_en && full;
        end
    end

    always_ff @(posedge clk_w) begin
        if (wr_fire) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // Read domain mirrors the write side; data_out only moves on an accepted read.
    assign rd_fire       = rd_en && !empty;
    assign rbin_next     = rptr + PW'(rd_fire);
    assign rgray_next    = PW'(bin2gray(32'(rbin_next)));
    assign empty_next    = (rgray_next == wgray_sync);
    assign rd_count_next = PW'(gray2bin(32'(wgray_sync))) - rbin_next;

    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            rptr         <= '0;
            rgray        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            underflow    <= 1'b0;
            data_out     <= '0;
        end else begin
            rptr         <= rbin_next;
            rgray        <= rgray_next;
            empty        <= empty_next;
            almost_empty <= (rd_count_next <= AE_CNT);
            rd_count     <= rd_count_next;
            underflow    <= rd_en && empty;
            if (rd_fire) begin
                data_out <= mem[rptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    gray_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk (clk_r),
        .rst (rst),
        .d   (wgray),
        .q   (wgray_sync)
    );

    gray_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk (clk_w),
        .rst (rst),
        .d   (rgray),
        .q   (rgray_sync)
    );

endmodule

// File: tb/tb_async_fifo_flags.sv
// Bench for async_fifo_flags: directed fill/drain/latency/reset/wrap phases plus a
// randomized dual-clock run against a queue-based reference model.
`timescale 1ns/1ps
module tb_async_fifo_flags;

    localparam int DW      = 8;
    localparam int DEPTH   = 16;
    localparam int PW      = 5;
    localparam int SYNC    = 3;
    localparam int N_WORDS = 10000;

    logic          clk_w   = 1'b0;
    logic          clk_r   = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, almost_full, overflow, empty, almost_empty, underflow;
    logic [PW-1:0] wr_count, rd_count;

    real hr_w = 5.0;
    real hr_r = 13.5;
    real sweep_hr [7] = '{15.03, 10.07, 7.51, 5.13, 3.37, 2.53, 1.71};

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] model_q [$];
    bit            wr_done = 1'b0;
    bit            rd_done = 1'b0;

    initial forever #(hr_w) clk_w = ~clk_w;
    initial begin
        #3.3;
        forever #(hr_r) clk_r = ~clk_r;
    end

    async_fifo_flags #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_w       (clk_w),
        .rst         (rst),
        .clk_r       (clk_r),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .full        (full),
        .almost_full (almost_full),
        .wr_count    (wr_count),
        .overflow    (overflow),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .empty       (empty),
        .almost_empty(almost_empty),
        .rd_count    (rd_count),
        .underflow   (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        @(negedge clk_w);
        wr_en   = 1'b1;
        data_in = d;
        @(negedge clk_w);
        wr_en = 1'b0;
        model_q.push_back(d);
    endtask

    task automatic pop_word();
        @(negedge clk_r);
        rd_en = 1'b1;
        @(negedge clk_r);
        rd_en = 1'b0;
        if (model_q.size() > 0) check("pop_data", 32'(data_out), 32'(model_q.pop_front()));
        else                    check("pop_model_empty", 32'(model_q.size()), 1);
    endtask

    task automatic wait_not_empty(input int budget, output int edges);
        edges = 0;
        while (empty && edges < budget) begin
            @(negedge clk_r);
            edges++;
        end
    endtask

    initial begin
        int            edges;
        int            n_wr, n_rd;
        bit            w_pen, w_pfull, r_pen, r_pempty;
        logic [DW-1:0] w_pdat, d, last_rd;
        real           t_lim;

        // Reset state
        repeat (6) @(posedge clk_r);
        #1;
        check("rst_full", 32'(full), 0);
        check("rst_af", 32'(almost_full), 0);
        check("rst_wcnt", 32'(wr_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_rcnt", 32'(rd_count), 0);
        check("rst_udf", 32'(underflow), 0);
        check("rst_dout", 32'(data_out), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk_r);

        // Fill to capacity with no reads, then one write too many
        @(negedge clk_w);
        wr_en   = 1'b1;
        data_in = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk_w);
            model_q.push_back(8'(i));
            check("fill_wcnt", 32'(wr_count), i + 1);
            check("fill_full", 32'(full), 32'(i == DEPTH - 1));
            check("fill_af", 32'(almost_full), 32'(i + 1 >= DEPTH - 2));
            data_in = (i == DEPTH - 1) ? 8'hEE : 8'(i + 1);
        end
        @(negedge clk_w);
        wr_en = 1'b0;
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_wcnt", 32'(wr_count), DEPTH);
        check("ovf_full", 32'(full), 1);
        @(negedge clk_w);
        check("ovf_clear", 32'(overflow), 0);

        // Continuous drain, then one read too many
        repeat (SYNC + 2) @(negedge clk_r);
        check("drain_rcnt0", 32'(rd_count), DEPTH);
        check("drain_empty0", 32'(empty), 0);
        check("drain_ae0", 32'(almost_empty), 0);
        last_rd = '0;
        rd_en = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            @(negedge clk_r);
            last_rd = model_q.pop_front();
            check("drain_data", 32'(data_out), 32'(last_rd));
            check("drain_rcnt", 32'(rd_count), DEPTH - 1 - j);
            check("drain_empty", 32'(empty), 32'(j == DEPTH - 1));
            check("drain_ae", 32'(almost_empty), 32'(DEPTH - 1 - j <= 2));
        end
        @(negedge clk_r);
        rd_en = 1'b0;
        check("udf_pulse", 32'(underflow), 1);
        check("udf_dout_hold", 32'(data_out), 32'(last_rd));
        @(negedge clk_r);
        check("udf_clear", 32'(underflow), 0);
        repeat (SYNC + 3) @(negedge clk_w);
        check("release_full", 32'(full), 0);
        check("release_wcnt", 32'(wr_count), 0);
        check("release_af", 32'(almost_full), 0);

        // Single write into empty FIFO: crossing latency
        check("lat_empty_before", 32'(empty), 1);
        @(negedge clk_w);
        wr_en   = 1'b1;
        data_in = 8'h3C;
        @(posedge clk_w);
        #0.5;
        wr_en = 1'b0;
        model_q.push_back(8'h3C);
        edges = 0;
        while (empty && edges < 10) begin
            @(posedge clk_r);
            #0.5;
            edges++;
        end
        check("lat_edges_ok", 32'(edges <= SYNC + 2), 1);
        @(negedge clk_r);
        check("lat_rcnt", 32'(rd_count), 1);
        check("lat_ae", 32'(almost_empty), 1);
        pop_word();
        check("lat_empty_after", 32'(empty), 1);

        // Randomized concurrent traffic with a sweeping clock ratio
        n_wr     = 0;
        n_rd     = 0;
        w_pen    = 1'b0;
        w_pfull  = 1'b0;
        w_pdat   = '0;
        r_pen    = 1'b0;
        r_pempty = 1'b1;
        t_lim    = $realtime + 900000.0;
        fork
            begin
                while (n_wr < N_WORDS && $realtime < t_lim) begin
                    @(negedge clk_w);
                    if (w_pen && !w_pfull) begin
                        model_q.push_back(w_pdat);
                        n_wr++;
                    end
                    check("rnd_ovf", 32'(overflow), 32'(w_pen && w_pfull));
                    check("rnd_full_cnt", 32'(full), 32'(wr_count == 5'd16));
                    check("rnd_af", 32'(almost_full), 32'(wr_count >= 5'd14));
                    w_pfull = full;
                    wr_en   = (n_wr < N_WORDS) && ($urandom_range(0, 99) < 70);
                    data_in = 8'($urandom);
                    w_pen   = wr_en;
                    w_pdat  = data_in;
                end
                wr_en   = 1'b0;
                wr_done = 1'b1;
            end
            begin
                while (n_rd < N_WORDS && $realtime < t_lim) begin
                    @(negedge clk_r);
                    if (r_pen && !r_pempty) begin
                        n_rd++;
                        if (model_q.size() > 0) check("rnd_data", 32'(data_out), 32'(model_q.pop_front()));
                        else                    check("rnd_dup", 32'(model_q.size()), 1);
                    end
                    check("rnd_udf", 32'(underflow), 32'(r_pen && r_pempty));
                    check("rnd_ae", 32'(almost_empty), 32'(rd_count <= 5'd2));
                    r_pempty = empty;
                    rd_en    = (n_rd < N_WORDS) && ($urandom_range(0, 99) < 70);
                    r_pen    = rd_en;
                end
                rd_en   = 1'b0;
                rd_done = 1'b1;
            end
            begin
                int k;
                k    = 0;
                hr_r = sweep_hr[0];
                while (!(wr_done && rd_done)) begin
                    #2000;
                    k    = (k + 1) % 7;
                    hr_r = sweep_hr[k];
                end
            end
        join
        hr_r = 13.5;
        check("rnd_wr_total", 32'(n_wr), N_WORDS);
        check("rnd_rd_total", 32'(n_rd), N_WORDS);
        check("rnd_model_left", 32'(model_q.size()), 0);
        repeat (SYNC + 3) @(negedge clk_r);
        check("rnd_end_empty", 32'(empty), 1);

        // Reset mid-stream with 9 words stored
        push_word(8'h5A);
        for (int i = 1; i < 10; i++) push_word(8'($urandom));
        repeat (SYNC + 2) @(negedge clk_r);
        pop_word();
        repeat (SYNC + 2) @(negedge clk_r);
        check("mid_rcnt", 32'(rd_count), 32'(model_q.size()));
        check("mid_wcnt", 32'(wr_count), 32'(model_q.size()));
        @(negedge clk_w);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_full", 32'(full), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_dout", 32'(data_out), 0);
        check("mid_rst_wcnt", 32'(wr_count), 0);
        check("mid_rst_rcnt", 32'(rd_count), 0);
        check("mid_rst_ae", 32'(almost_empty), 1);
        model_q.delete();
        repeat (5) @(negedge clk_r);
        rst = 1'b0;
        repeat (3) @(negedge clk_r);
        push_word(8'hA5);
        wait_not_empty(10, edges);
        check("mid_after_vis", 32'(empty), 0);
        pop_word();

        // Pointer wrap: single write/read pairs across the pointer rollover
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            push_word(d);
            check("wrap_full", 32'(full), 0);
            check("wrap_wcnt", 32'(wr_count <= 5'd2), 1);
            wait_not_empty(10, edges);
            check("wrap_lat", 32'(edges <= SYNC + 2), 1);
            check("wrap_rcnt", 32'(rd_count), 1);
            pop_word();
            check("wrap_empty", 32'(empty), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
